// File: rtl/uart_imem_loader.sv
// UART boot loader: receives 8N1 bytes on uart_rxd while load_imem is high, packs
// them little-endian into 32-bit words and writes them to sequential imem word addresses.
module uart_imem_loader #(
    parameter int unsigned BAUD_DIV        = 434,
    parameter int unsigned IMEM_ADDR_WIDTH = 14
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_imem,
    input  logic                       uart_rxd,
    output logic                       imem_wr,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]                imem_wdata,
    output logic                       busy,
    output logic                       frame_err,
    output logic [IMEM_ADDR_WIDTH:0]   word_cnt
);

    localparam int unsigned AW = IMEM_ADDR_WIDTH;
    localparam int unsigned TW = $clog2(BAUD_DIV);

    localparam logic [TW-1:0] HALF_LOAD = TW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(BAUD_DIV - 1);
    localparam logic [AW:0]   CNT_MAX   = {1'b1, {AW{1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    state_e        state_q;
    logic          rxd_meta_q;
    logic          rxd_s_q;
    logic          load_prev_q;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic [1:0]    byte_idx_q;
    logic [31:0]   word_q;
    logic [31:0]   word_d;
    logic [AW-1:0] ptr_q;
    logic          imem_wr_q;
    logic [AW-1:0] imem_addr_q;
    logic [31:0]   imem_wdata_q;
    logic          busy_q;
    logic          frame_err_q;
    logic [AW:0]   word_cnt_q;

    // Word buffer with the just-received byte merged into its lane
    always_comb begin
        word_d = word_q;
        word_d[{byte_idx_q, 3'b000} +: 8] = shift_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rxd_meta_q   <= 1'b1;
            rxd_s_q      <= 1'b1;
            load_prev_q  <= 1'b0;
            timer_q      <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            ptr_q        <= '0;
            imem_wr_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            word_cnt_q   <= '0;
        end else begin
            rxd_meta_q  <= uart_rxd;
            rxd_s_q     <= rxd_meta_q;
            load_prev_q <= load_imem;
            imem_wr_q   <= 1'b0;

            if (!load_imem) begin
                // Loader disabled: abandon any frame and partial word
                state_q    <= IDLE;
                busy_q     <= 1'b0;
                byte_idx_q <= '0;
            end else begin
                if (!load_prev_q) begin
                    ptr_q       <= '0;
                    word_cnt_q  <= '0;
                    byte_idx_q  <= '0;
                    frame_err_q <= 1'b0;
                end

                unique case (state_q)
                    IDLE: begin
                        if (!rxd_s_q) begin
                            state_q <= START;
                            busy_q  <= 1'b1;
                            timer_q <= HALF_LOAD;
                        end
                    end

                    START: begin
                        if (timer_q == '0) begin
                            if (!rxd_s_q) begin
                                state_q <= DATA;
                                timer_q <= FULL_LOAD;
                                bit_q   <= '0;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end

                    DATA: begin
                        if (timer_q == '0) begin
                            shift_q <= {rxd_s_q, shift_q[7:1]};
                            timer_q <= FULL_LOAD;
                            if (bit_q == 3'd7) begin
                                state_q <= STOP;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                            end
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end

                    STOP: begin
                        if (timer_q == '0) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (rxd_s_q) begin
                                word_q     <= word_d;
                                byte_idx_q <= byte_idx_q + 2'd1;
                                // Fourth lane filled: issue the word write
                                if (byte_idx_q == 2'd3) begin
                                    imem_wr_q    <= 1'b1;
                                    imem_addr_q  <= ptr_q;
                                    imem_wdata_q <= word_d;
                                    ptr_q        <= ptr_q + AW'(1);
                                    if (word_cnt_q != CNT_MAX) begin
                                        word_cnt_q <= word_cnt_q + (AW+1)'(1);
                                    end
                                end
                            end else begin
                                frame_err_q <= 1'b1;
                            end
                        end else begin
                            timer_q <= timer_q - TW'(1);
                        end
                    end

                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign imem_wr    = imem_wr_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign word_cnt   = word_cnt_q;

endmodule
